// File: rtl/imul_seq_param.sv
// Sequential shift-and-add multiplier retiring STEP multiplier bits per clock.
// Optional two's-complement mode is built in when IMUL_SIGNED_EN is defined.
module imul_seq_param #(
    parameter int NB   = 16,
    parameter int STEP = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iStart,
    input  logic [NB-1:0]     iA,
    input  logic [NB-1:0]     iB,
`ifdef IMUL_SIGNED_EN
    input  logic              iSigned,
`endif
    output logic              oReady,
    output logic              oDone,
    output logic [2*NB-1:0]   oResult
);

    localparam int N  = NB / STEP;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [NB-1:0]     mcand;
    logic [NB-1:0]     mplier;
    logic [2*NB-1:0]   acc;
    logic [CW-1:0]     cnt;
    logic [NB+STEP-1:0] prod;
    logic [2*NB-1:0]   pp;

`ifdef IMUL_SIGNED_EN
    logic              neg;
    logic [NB-1:0]     abs_a;
    logic [NB-1:0]     abs_b;

    // Magnitude of the most-negative value is 2^(NB-1), still exact as unsigned NB bits.
    always_comb begin
        abs_a = iA;
        abs_b = iB;
        if (iSigned && iA[NB-1]) abs_a = ~iA + NB'(1);
        if (iSigned && iB[NB-1]) abs_b = ~iB + NB'(1);
    end
`endif

    always_comb begin
        prod = (NB+STEP)'(mcand) * (NB+STEP)'(mplier[STEP-1:0]);
        pp   = (2*NB)'(prod) << (cnt * STEP);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            oReady  <= 1'b1;
            oDone   <= 1'b0;
            oResult <= '0;
            acc     <= '0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
`ifdef IMUL_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
`ifdef IMUL_SIGNED_EN
                        mcand  <= abs_a;
                        mplier <= abs_b;
                        neg    <= iSigned & (iA[NB-1] ^ iB[NB-1]);
`else
                        mcand  <= iA;
                        mplier <= iB;
`endif
                        acc    <= '0;
                        cnt    <= '0;
                        oReady <= 1'b0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc + pp;
                    mplier <= mplier >> STEP;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) state <= DONE;
                end
                DONE: begin
`ifdef IMUL_SIGNED_EN
                    oResult <= neg ? (~acc + (2*NB)'(1)) : acc;
`else
                    oResult <= acc;
`endif
                    oDone  <= 1'b1;
                    oReady <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    oReady <= 1'b1;
                    oDone  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imul_seq_param.sv
// Directed bench for imul_seq_param with STEP=1 and STEP=4 instances at NB=16.
// Signed vectors are exercised only when IMUL_SIGNED_EN is defined.
module tb_imul_seq_param;

    logic        clk;
    logic        rst;
    logic        st1, st4;
    logic [15:0] a1, b1, a4, b4;
    logic        rdy1, dn1, rdy4, dn4;
    logic [31:0] res1, res4;
`ifdef IMUL_SIGNED_EN
    logic        sg1, sg4;
`endif

    int errors = 0;
    int checks = 0;

    imul_seq_param #(.NB(16), .STEP(1)) u1 (
        .Clock(clk), .Reset(rst), .iStart(st1), .iA(a1), .iB(b1),
`ifdef IMUL_SIGNED_EN
        .iSigned(sg1),
`endif
        .oReady(rdy1), .oDone(dn1), .oResult(res1)
    );

    imul_seq_param #(.NB(16), .STEP(4)) u4 (
        .Clock(clk), .Reset(rst), .iStart(st4), .iA(a4), .iB(b4),
`ifdef IMUL_SIGNED_EN
        .iSigned(sg4),
`endif
        .oReady(rdy4), .oDone(dn4), .oResult(res4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation on the selected instance: checks acceptance, latency, result and hold.
    task automatic run_op(input bit sel4, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input string tag);
        int lat;
        int cnt;
        bit got;
        lat = sel4 ? 5 : 17;
        @(negedge clk);
        if (sel4) begin a4 = a; b4 = b; st4 = 1'b1; end
        else      begin a1 = a; b1 = b; st1 = 1'b1; end
        @(posedge clk); #1;
        st1 = 1'b0; st4 = 1'b0;
        chk({tag, "_accept"}, {63'd0, sel4 ? rdy4 : rdy1}, 64'd0);
        // scramble operands after acceptance
        if (sel4) begin a4 = ~a; b4 = ~b; end else begin a1 = ~a; b1 = ~b; end
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 60) begin
            @(posedge clk); #1;
            cnt++;
            got = sel4 ? dn4 : dn1;
        end
        chk({tag, "_lat"}, 64'(cnt), 64'(lat));
        chk({tag, "_res"}, {32'd0, sel4 ? res4 : res1}, {32'd0, exp});
        chk({tag, "_rdy"}, {63'd0, sel4 ? rdy4 : rdy1}, 64'd1);
        @(posedge clk); #1;
        chk({tag, "_hold"}, {31'd0, sel4 ? dn4 : dn1, sel4 ? res4 : res1}, {32'd0, exp});
    endtask

    initial begin
        logic [15:0] ca [3];
        logic [15:0] cb [3];
        logic [31:0] ce [3];
        rst = 1'b1;
        st1 = 1'b0; st4 = 1'b0;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0;
`ifdef IMUL_SIGNED_EN
        sg1 = 1'b0; sg4 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy1", {63'd0, rdy1}, 64'd1);
        chk("rst_dn1",  {63'd0, dn1},  64'd0);
        chk("rst_res1", {32'd0, res1}, 64'd0);
        chk("rst_rdy4", {63'd0, rdy4}, 64'd1);
        chk("rst_res4", {32'd0, res4}, 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "s1_max");
        run_op(1'b0, 16'hABCD, 16'h0000, 32'h00000000, "s1_b0");
        run_op(1'b0, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, "s1_7fff");
        run_op(1'b1, 16'h1234, 16'h5678, 32'h06260060, "s4_1234");
        run_op(1'b1, 16'h0000, 16'hABCD, 32'h00000000, "s4_a0");
        run_op(1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "s4_max");
        run_op(1'b1, 16'h00FF, 16'h0100, 32'h0000FF00, "s4_ff00");

        // iStart held high: one result per 18 cycles, operands junk between acceptances
        ca[0] = 16'h00FF; cb[0] = 16'h0100; ce[0] = 32'h0000FF00;
        ca[1] = 16'h7FFF; cb[1] = 16'h7FFF; ce[1] = 32'h3FFF0001;
        ca[2] = 16'hFFFF; cb[2] = 16'h0001; ce[2] = 32'h0000FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a1 = ca[i]; b1 = cb[i]; st1 = 1'b1;
            @(posedge clk); #1;
            chk("cont_accept", {63'd0, rdy1}, 64'd0);
            for (int j = 1; j <= 17; j++) begin
                @(negedge clk);
                a1 = 16'($urandom); b1 = 16'($urandom);
                @(posedge clk); #1;
                if (j < 17) chk("cont_busy", {62'd0, rdy1, dn1}, 64'd0);
                else        chk("cont_res", {31'd0, dn1, res1}, {31'd0, 1'b1, ce[i]});
            end
        end
        @(negedge clk); st1 = 1'b0;
        @(posedge clk); #1;
        chk("cont_idle", {31'd0, dn1, res1}, {32'd0, ce[2]});

        // Reset during the 5th BUSY cycle
        @(negedge clk);
        a1 = 16'h1234; b1 = 16'h5678; st1 = 1'b1;
        @(posedge clk); #1;
        st1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst", {30'd0, rdy1, dn1, res1}, {30'd0, 2'b10, 32'd0});
        @(negedge clk); rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_quiet", {30'd0, rdy1, dn1, res1}, {30'd0, 2'b10, 32'd0});
        run_op(1'b0, 16'h0F0F, 16'h0010, 32'h0000F0F0, "post_rst");

`ifdef IMUL_SIGNED_EN
        sg1 = 1'b1; sg4 = 1'b1;
        run_op(1'b0, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, "sg_m3x5");
        run_op(1'b0, 16'h8000, 16'h8000, 32'h40000000, "sg_minmin");
        run_op(1'b0, 16'h8000, 16'h0001, 32'hFFFF8000, "sg_minx1");
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 32'h00000001, "sg_m1m1");
        run_op(1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, "sg4_m3x5");
        run_op(1'b1, 16'h0007, 16'hFFFA, 32'hFFFFFFD6, "sg4_7xm6");
        sg1 = 1'b0; sg4 = 1'b0;
        run_op(1'b0, 16'h8000, 16'h8000, 32'h40000000, "us_8000");
        run_op(1'b0, 16'hFFFF, 16'h0002, 32'h0001FFFE, "us_ffffx2");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
